// File: rtl/data_sram_ctrl.sv
// data_sram_ctrl: 32-bit data port onto a 16-bit async SRAM, done as HI then LO halves.
// Optional feature macro DMEM_RDY_EN: each half also waits for sram_rdy_i.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   mem_ce_i/we_i     access request / write select from the memory-access stage
//   mem_addr_i        byte address, bits [20:2] used
//   mem_sel_i         byte enables, bit 3 = bits [31:24]
//   mem_data_i        write data
//   stall_i           pipeline held elsewhere; keeps DONE
//   mem_data_o        read data
//   stallreq_o        stall request while access in flight
//   sram_addr_o       halfword address
//   sram_data_o/i     SRAM write / read data
//   sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o  active-low strobes
//   sram_rdy_i        SRAM ready, used only with DMEM_RDY_EN
module data_sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    input  logic        stall_i,
    output logic [31:0] mem_data_o,
    output logic        stallreq_o,
    output logic [19:0] sram_addr_o,
    output logic [15:0] sram_data_o,
    input  logic [15:0] sram_data_i,
    output logic        sram_ce_n_o,
    output logic        sram_oe_n_o,
    output logic        sram_we_n_o,
    output logic [1:0]  sram_be_n_o,
    input  logic        sram_rdy_i
);

    typedef enum logic [1:0] {
        IDLE,
        HI,
        LO,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [18:0] addr_q;
    logic        we_q;
    logic [3:0]  sel_q;
    logic [31:0] data_q;
    logic [2:0]  cnt;
    logic        half_done;
    logic        enter;
    logic [15:0] hi_mask;
    logic [15:0] lo_mask;
    logic        unused_addr;

    assign unused_addr = ^{mem_addr_i[31:21], mem_addr_i[1:0]};

`ifdef DMEM_RDY_EN
    assign half_done = (cnt == 3'd0) && sram_rdy_i;
`else
    logic unused_rdy;
    assign unused_rdy = sram_rdy_i;
    assign half_done  = (cnt == 3'd0);
`endif

    // Entering a half (from IDLE or HI->LO) reloads the wait counter.
    assign enter = ((state_nx == HI) && (state != HI))
                || ((state_nx == LO) && (state != LO));

    assign hi_mask = {{8{sel_q[3]}}, {8{sel_q[2]}}};
    assign lo_mask = {{8{sel_q[1]}}, {8{sel_q[0]}}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (mem_ce_i) begin
                    if (|mem_sel_i[3:2]) begin
                        state_nx = HI;
                    end else if (|mem_sel_i[1:0]) begin
                        state_nx = LO;
                    end else begin
                        state_nx = DONE;
                    end
                end
            end
            HI: begin
                if (half_done) begin
                    state_nx = (|sel_q[1:0]) ? LO : DONE;
                end
            end
            LO: begin
                if (half_done) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (!stall_i) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= '0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            data_q     <= '0;
            cnt        <= '0;
            mem_data_o <= '0;
        end else begin
            if ((state == IDLE) && mem_ce_i) begin
                addr_q     <= mem_addr_i[20:2];
                we_q       <= mem_we_i;
                sel_q      <= mem_sel_i;
                data_q     <= mem_data_i;
                mem_data_o <= '0;
            end
            if (enter) begin
                cnt <= 3'(WAIT_CYCLES);
            end else if (((state == HI) || (state == LO))
                         && (cnt != 3'd0)) begin
                cnt <= cnt - 3'd1;
            end
            if ((state == HI) && half_done && !we_q) begin
                mem_data_o[31:16] <= sram_data_i & hi_mask;
            end
            if ((state == LO) && half_done && !we_q) begin
                mem_data_o[15:0] <= sram_data_i & lo_mask;
            end
        end
    end

    always_comb begin
        sram_addr_o = '0;
        sram_data_o = '0;
        sram_ce_n_o = 1'b1;
        sram_oe_n_o = 1'b1;
        sram_we_n_o = 1'b1;
        sram_be_n_o = 2'b11;
        stallreq_o  = 1'b0;
        unique case (1'b1)
            (state == HI): begin
                sram_addr_o = {addr_q, 1'b0};
                sram_data_o = data_q[31:16];
                sram_be_n_o = ~sel_q[3:2];
                sram_ce_n_o = 1'b0;
                sram_we_n_o = ~we_q;
                sram_oe_n_o = we_q;
                stallreq_o  = 1'b1;
            end
            (state == LO): begin
                sram_addr_o = {addr_q, 1'b1};
                sram_data_o = data_q[15:0];
                sram_be_n_o = ~sel_q[1:0];
                sram_ce_n_o = 1'b0;
                sram_we_n_o = ~we_q;
                sram_oe_n_o = we_q;
                stallreq_o  = 1'b1;
            end
            // Gated by rst so a held request reads as idle in reset.
            (state == IDLE): stallreq_o = rst & mem_ce_i;
            default: ;
        endcase
    end

endmodule
